// File: rtl/nios_pio_in_irq_pkg.sv
// Shared constants for the PIO input/IRQ block: register addresses and edge-mode encodings.
package nios_pio_in_irq_pkg;

  localparam int unsigned BUS_WIDTH = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_in_irq_if.sv
// Avalon-MM slave bus bundle for the PIO input block.
interface nios_pio_in_irq_if;
  import nios_pio_in_irq_pkg::*;

  logic [1:0]           address;
  logic                 chipselect;
  logic                 write_n;
  logic [BUS_WIDTH-1:0] writedata;
  logic [BUS_WIDTH-1:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_sync.sv
// Multi-flop synchronizer for asynchronous PIO inputs.
module pio_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/nios_pio_in_irq.sv
// PIO input port with edge capture, interrupt mask and level IRQ on an Avalon-MM slave.
module nios_pio_in_irq
  import nios_pio_in_irq_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  nios_pio_in_irq_if.slave   bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  localparam logic [2:0] ArmMax = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]     sync_s;
  logic [WIDTH-1:0]     prev_q;
  logic [WIDTH-1:0]     edge_raw;
  logic [WIDTH-1:0]     edge_s;
  logic [WIDTH-1:0]     clr;
  logic [WIDTH-1:0]     irqmask_q, irqmask_d;
  logic [WIDTH-1:0]     edgecap_q, edgecap_d;
  logic [2:0]           arm_q, arm_d;
  logic                 armed;
  logic                 wr_en;
  logic [BUS_WIDTH-1:0] readdata_q, readdata_d;
  logic                 unused_wdata;

  pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (in_port),
    .q_o    (sync_s)
  );

  if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign edge_raw = ~sync_s & prev_q;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    assign edge_raw = sync_s ^ prev_q;
  end else begin : g_rise
    assign edge_raw = sync_s & ~prev_q;
  end

  // Edges are masked until the sync chain and prev have been filled from the live input.
  assign armed  = (arm_q == ArmMax);
  assign arm_d  = armed ? arm_q : arm_q + 3'd1;
  assign edge_s = armed ? edge_raw : '0;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    irqmask_d = irqmask_q;
    clr       = '0;
    if (wr_en) begin
      case (bus.address)
        ADDR_IRQMASK: irqmask_d = bus.writedata[WIDTH-1:0];
        ADDR_EDGECAP: clr       = bus.writedata[WIDTH-1:0];
        default:      ;
      endcase
    end
    // A new edge wins over a simultaneous clear of the same bit.
    edgecap_d = (edgecap_q & ~clr) | edge_s;
  end

  always_comb begin
    readdata_d = '0;
    unique case (bus.address)
      ADDR_DATA:    readdata_d = BUS_WIDTH'(sync_s);
      ADDR_RSVD:    readdata_d = '0;
      ADDR_IRQMASK: readdata_d = BUS_WIDTH'(irqmask_q);
      ADDR_EDGECAP: readdata_d = BUS_WIDTH'(edgecap_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      arm_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= sync_s;
      arm_q      <= arm_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_pio_in_irq.sv
// Directed bench: rising-edge 2-stage instance and any-edge 3-stage instance share one bus driver.
module tb_nios_pio_in_irq;
  import nios_pio_in_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs;
  logic        wr_n;
  logic [31:0] wdata;
  logic [7:0]  in_a, in_b;
  logic        irq_a, irq_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_pio_in_irq_if bus_a ();
  nios_pio_in_irq_if bus_b ();

  assign bus_a.address    = address;
  assign bus_a.chipselect = cs;
  assign bus_a.write_n    = wr_n;
  assign bus_a.writedata  = wdata;
  assign bus_b.address    = address;
  assign bus_b.chipselect = cs;
  assign bus_b.write_n    = wr_n;
  assign bus_b.writedata  = wdata;

  nios_pio_in_irq #(
    .WIDTH      (8),
    .EDGE_TYPE  (0),
    .SYNC_STAGES(2)
  ) u_dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_a),
    .in_port(in_a),
    .irq    (irq_a)
  );

  nios_pio_in_irq #(
    .WIDTH      (8),
    .EDGE_TYPE  (2),
    .SYNC_STAGES(3)
  ) u_dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_b),
    .in_port(in_b),
    .irq    (irq_b)
  );

  typedef struct {
    logic [7:0]  in_a;
    bit          wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    address = a;
    cs      = 1'b1;
    wr_n    = 1'b0;
    wdata   = d;
    tick();
    cs      = 1'b0;
    wr_n    = 1'b1;
    wdata   = '0;
  endtask

  task automatic bus_read(bit sel, logic [1:0] a, output logic [31:0] d);
    address = a;
    cs      = 1'b1;
    wr_n    = 1'b1;
    tick();
    d  = sel ? bus_b.readdata : bus_a.readdata;
    cs = 1'b0;
  endtask

  // Input changes just after an edge; readdata at EDGECAP must stay 0 for stages+1 edges.
  task automatic latency(bit sel, logic [7:0] new_in, logic [31:0] exp, int stages, string name);
    logic [31:0] rd;
    address = ADDR_EDGECAP;
    cs      = 1'b0;
    wr_n    = 1'b1;
    if (sel) in_b = new_in;
    else     in_a = new_in;
    for (int i = 0; i <= stages; i++) begin
      tick();
      rd = sel ? bus_b.readdata : bus_a.readdata;
      check({name, "_early"}, rd, 32'h0);
    end
    tick();
    rd = sel ? bus_b.readdata : bus_a.readdata;
    check(name, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{8'h08, 1'b1, ADDR_IRQMASK, 32'h0000_00FF, ADDR_IRQMASK, 32'hFF, 1'b0};
    vecs[1]  = '{8'h09, 1'b0, ADDR_DATA,    32'h0000_0000, ADDR_EDGECAP, 32'h01, 1'b1};
    vecs[2]  = '{8'h09, 1'b1, ADDR_IRQMASK, 32'h1234_5A02, ADDR_IRQMASK, 32'h02, 1'b0};
    vecs[3]  = '{8'h0B, 1'b0, ADDR_DATA,    32'h0000_0000, ADDR_EDGECAP, 32'h03, 1'b1};
    vecs[4]  = '{8'h0B, 1'b1, ADDR_EDGECAP, 32'h0000_0002, ADDR_EDGECAP, 32'h01, 1'b0};
    vecs[5]  = '{8'h0B, 1'b1, ADDR_DATA,    32'h0000_00FF, ADDR_DATA,    32'h0B, 1'b0};
    vecs[6]  = '{8'h0B, 1'b1, ADDR_RSVD,    32'h0000_00FF, ADDR_RSVD,    32'h00, 1'b0};
    vecs[7]  = '{8'h0B, 1'b1, ADDR_IRQMASK, 32'h0000_0001, ADDR_IRQMASK, 32'h01, 1'b1};
    vecs[8]  = '{8'h03, 1'b1, ADDR_EDGECAP, 32'hFFFF_FFFF, ADDR_EDGECAP, 32'h00, 1'b0};
    vecs[9]  = '{8'hF3, 1'b1, ADDR_IRQMASK, 32'h0000_00F0, ADDR_EDGECAP, 32'hF0, 1'b1};
    vecs[10] = '{8'h00, 1'b1, ADDR_EDGECAP, 32'h0000_0030, ADDR_EDGECAP, 32'hC0, 1'b1};
    vecs[11] = '{8'h00, 1'b1, ADDR_EDGECAP, 32'h0000_00C0, ADDR_EDGECAP, 32'h00, 1'b0};

    reset_n = 1'b0;
    address = ADDR_DATA;
    cs      = 1'b0;
    wr_n    = 1'b1;
    wdata   = '0;
    in_a    = 8'hFF;
    in_b    = 8'h01;
    repeat (3) tick();
    check("reset_readdata", bus_a.readdata, 32'h0);
    check("reset_irq", {31'b0, irq_a}, 32'h0);

    // Inputs already high at release must not register as edges.
    reset_n = 1'b1;
    repeat (8) tick();
    bus_read(1'b0, ADDR_EDGECAP, rd);
    check("arm_edgecap", rd, 32'h0);
    check("arm_irq", {31'b0, irq_a}, 32'h0);
    bus_read(1'b0, ADDR_DATA, rd);
    check("data_ff", rd, 32'hFF);

    in_a = 8'h00;
    repeat (4) tick();
    bus_read(1'b0, ADDR_EDGECAP, rd);
    check("fall_ignored", rd, 32'h0);

    latency(1'b0, 8'h08, 32'h8, 2, "lat_a");

    bus_write(ADDR_IRQMASK, 32'h08);
    check("mask_irq_on", {31'b0, irq_a}, 32'h1);
    bus_read(1'b0, ADDR_IRQMASK, rd);
    check("mask_read", rd, 32'h08);
    bus_write(ADDR_EDGECAP, 32'h08);
    check("clear_irq_off", {31'b0, irq_a}, 32'h0);
    bus_read(1'b0, ADDR_EDGECAP, rd);
    check("clear_edgecap", rd, 32'h0);

    for (int i = 0; i < 12; i++) begin
      in_a    = vecs[i].in_a;
      address = vecs[i].raddr;
      repeat (4) tick();
      if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdata);
      bus_read(1'b0, vecs[i].raddr, rd);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq_a}, {31'b0, vecs[i].exp_irq});
    end

    // Set bit3, then land a fresh bit3 edge on the same edge as its clear.
    bus_write(ADDR_IRQMASK, 32'h08);
    in_a    = 8'h08;
    address = ADDR_EDGECAP;
    repeat (4) tick();
    in_a = 8'h00;
    repeat (4) tick();
    in_a = 8'h08;
    repeat (2) tick();
    bus_write(ADDR_EDGECAP, 32'h08);
    bus_read(1'b0, ADDR_EDGECAP, rd);
    check("collide_edgecap", rd, 32'h08);
    check("collide_irq", {31'b0, irq_a}, 32'h1);

    in_a = 8'h00;
    repeat (4) tick();
    bus_write(ADDR_EDGECAP, 32'hFF);
    in_a = 8'h5A;
    repeat (4) tick();
    bus_write(ADDR_IRQMASK, 32'hFF);
    bus_read(1'b0, ADDR_EDGECAP, rd);
    check("pre_reset_edgecap", rd, 32'h5A);
    check("pre_reset_irq", {31'b0, irq_a}, 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_readdata", bus_a.readdata, 32'h0);
    check("async_irq", {31'b0, irq_a}, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    bus_read(1'b0, ADDR_IRQMASK, rd);
    check("post_reset_mask", rd, 32'h0);
    bus_read(1'b0, ADDR_EDGECAP, rd);
    check("post_reset_edgecap", rd, 32'h0);
    check("post_reset_irq", {31'b0, irq_a}, 32'h0);
    bus_read(1'b0, ADDR_DATA, rd);
    check("post_reset_data", rd, 32'h5A);

    bus_read(1'b1, ADDR_EDGECAP, rd);
    check("b_arm_edgecap", rd, 32'h0);
    latency(1'b1, 8'h00, 32'h1, 3, "lat_b_fall");
    bus_write(ADDR_EDGECAP, 32'h01);
    bus_read(1'b1, ADDR_EDGECAP, rd);
    check("b_cleared", rd, 32'h0);
    latency(1'b1, 8'h01, 32'h1, 3, "lat_b_rise");
    bus_write(ADDR_EDGECAP, 32'hFF);
    in_b = 8'hFE;
    repeat (5) tick();
    bus_read(1'b1, ADDR_EDGECAP, rd);
    check("b_all_toggle", rd, 32'hFF);
    check("b_irq_masked", {31'b0, irq_b}, 32'h0);
    bus_write(ADDR_IRQMASK, 32'h80);
    check("b_irq_on", {31'b0, irq_b}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_pio_in_irq.md
NIOS_PIO_IN_IRQ -- requirements
Module: nios_pio_in_irq

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WIDTH, 8, input port width, legal 1..32.
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, synchronizer depth, legal 2..3.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all logic on rising edge.
- reset_n, in, 1, reset, asynchronous, active-low.
- address, in, 2, Avalon-MM word address.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write strobe.
- writedata, in, 32, write data.
- in_port, in, WIDTH, asynchronous external inputs.
- readdata, out, 32, registered read data.
- irq, out, 1, level interrupt, active-high.

Function
REQ-003 The register map SHALL be: 0 DATA (RO, synchronized in_port); 1 reserved (reads 0, writes ignored); 2 IRQMASK (RW, WIDTH bits); 3 EDGECAP (read; write-1-to-clear per bit).
REQ-004 readdata SHALL update every clock, regardless of chipselect, with the selected register zero-extended to 32 bits; read latency is 1 cycle.
REQ-005 in_port SHALL pass through a SYNC_STAGES-deep flop chain; the sync output is DATA; one further flop holds the previous value, prev.
REQ-006 The edge vector SHALL be sync & ~prev (EDGE_TYPE 0), ~sync & prev (EDGE_TYPE 1), or sync ^ prev (EDGE_TYPE 2).
REQ-007 An arm counter SHALL count from 0 to SYNC_STAGES+1 after reset and then saturate; the edge vector SHALL be forced to 0 until the counter saturates, so no spurious edges occur while the pipeline fills.
REQ-008 EDGECAP bit i SHALL set on edge[i] and hold until cleared.
REQ-009 A write (chipselect=1, write_n=0) to address 3 SHALL clear each EDGECAP bit whose writedata bit is 1.
REQ-010 When a clear and a new edge hit the same bit in the same cycle, set SHALL win.
REQ-011 A write to address 2 SHALL load IRQMASK from writedata[WIDTH-1:0]; writedata bits at WIDTH and above are ignored.
REQ-012 Writes to addresses 0 and 1 SHALL have no effect.
REQ-013 irq SHALL be the OR-reduction of (EDGECAP & IRQMASK), driven combinationally from registers with no added latency.
REQ-014 Latency SHALL be SYNC_STAGES+1 cycles from an in_port transition to the EDGECAP bit set, and 1 further cycle to readdata.
REQ-015 Writes SHALL take effect on the clock edge they are sampled; a read of the same register in the next cycle SHALL return the new value.

Reset
REQ-016 Asserting reset_n low SHALL asynchronously zero the sync chain, prev, arm counter, IRQMASK, EDGECAP, and readdata; irq is therefore 0.
REQ-017 Reset asserted mid-operation SHALL discard all pending captures; re-arming restarts per REQ-007.

Structure
REQ-018 A shared package SHALL hold the address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and the EDGE_TYPE encodings.
REQ-019 The synchronizer SHALL be a separate sub-module, pio_sync, parametrised by WIDTH and SYNC_STAGES.

Verification
REQ-020 Hold in_port=8'hFF through reset release, EDGE_TYPE 0 -> EDGECAP stays 8'h00, irq=0.
REQ-021 Pulse in_port bit3 0->1 -> EDGECAP=8'h08 after SYNC_STAGES+1 cycles; read address 3 returns 32'h8 one cycle later.
REQ-022 Write IRQMASK=8'h08 with EDGECAP=8'h08 -> irq=1; write 8'h08 to address 3 -> EDGECAP=0, irq=0 the next cycle.
REQ-023 A clear of bit3 in the same cycle as a new bit3 edge -> EDGECAP bit3 remains 1.
REQ-024 EDGE_TYPE 2, toggle bit0 1->0 then 0->1, clearing in between -> each transition captures.
REQ-025 Assert reset_n low with EDGECAP=8'h5A and IRQMASK=8'hFF -> all registers 0 and irq=0 immediately, without waiting for a clock edge.
